// File: rtl/display_pkg.sv
// display_pkg
// Shared constants and types for the seven-segment scan controller:
// anode patterns per slot, the dash code, digit count and the BCD
// value-plus-sign record that the double buffer stores.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low anode patterns, one digit lit per slot
    localparam logic [3:0] AN_SLOT0 = 4'b1110;
    localparam logic [3:0] AN_SLOT1 = 4'b1101;
    localparam logic [3:0] AN_SLOT2 = 4'b1011;
    localparam logic [3:0] AN_SLOT3 = 4'b0111;
    localparam logic [3:0] AN_OFF   = 4'b1111;

    // Decoder code that renders a minus sign
    localparam logic [3:0] CODE_DASH = 4'd10;

    // Four BCD digits, element [0] is the rightmost digit
    typedef logic [NUM_DIGITS-1:0][3:0] bcd_digits_t;

    // Displayed value together with its sign
    typedef struct packed {
        logic        neg;
        bcd_digits_t d;
    } bcd4_t;

    // Anode pattern for a scan slot
    function automatic logic [3:0] anode_for_slot(input logic [1:0] slot);
        logic [3:0] an;
        case (slot)
            2'd0:    an = AN_SLOT0;
            2'd1:    an = AN_SLOT1;
            2'd2:    an = AN_SLOT2;
            2'd3:    an = AN_SLOT3;
            default: an = AN_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// display_scan_controller_if
// Valid/ready update channel into the scan controller.
//   upd_value : four BCD digits, [3:0] rightmost
//   upd_neg   : value is negative (shown only in answer mode)
//   upd_valid : producer offers an update
//   upd_ready : controller can take an update this cycle
// master = producer of updates, slave = scan controller.
interface display_scan_controller_if;
    import display_pkg::*;

    bcd_digits_t upd_value;
    logic        upd_neg;
    logic        upd_valid;
    logic        upd_ready;

    modport master (
        output upd_value,
        output upd_neg,
        output upd_valid,
        input  upd_ready
    );

    modport slave (
        input  upd_value,
        input  upd_neg,
        input  upd_valid,
        output upd_ready
    );

endinterface

// File: rtl/refresh_tick.sv
// refresh_tick
// Free-running prescaler counting 0..DIV-1; o_tick is high during the
// cycle the count sits at DIV-1. Kept generic so blink/timeout logic can
// reuse it.
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   o_tick : one-cycle pulse every DIV cycles
module refresh_tick #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_count;
    logic          w_at_end;

    assign w_at_end = (r_count == CW'(DIV - 1));
    assign o_tick   = w_at_end;

    // Prescaler counter with wrap at DIV-1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_at_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexes a 4-digit seven-segment display. Holds a double
// buffered BCD value (updates land only on frame boundaries) and applies
// answer-mode leading-zero blanking and minus sign.
//   clk, rst_n  : clock, synchronous active-low reset
//   upd_if      : update channel (value, neg, valid/ready)
//   show_ans    : answer mode (blanking + sign, no decimal point)
//   enable      : active-low anodes, one low or all high
//   digit       : code for the segment decoder (10 = dash)
//   dp_on       : decimal point request for the current slot
//   frame_done  : one-cycle pulse after each frame boundary
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    display_scan_controller_if.slave    upd_if,
    input  logic                        show_ans,
    output logic [3:0]                  enable,
    output logic [3:0]                  digit,
    output logic                        dp_on,
    output logic                        frame_done
);

    logic        w_tick;
    logic        w_boundary;
    logic        w_accept;
    logic [1:0]  r_idx;
    bcd4_t       r_active;
    bcd4_t       r_pending;
    logic        r_pend_full;

    logic        w_blank;
    logic [3:0]  w_code;
    logic [3:0]  w_anode;
    logic        w_dp;
    logic        w_d3z;
    logic        w_d2z;
    logic        w_d1z;

    refresh_tick #(
        .DIV (REFRESH_DIV)
    ) u_refresh_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    assign w_boundary       = w_tick && (r_idx == 2'd3);
    assign w_accept         = upd_if.upd_valid && !r_pend_full;
    assign upd_if.upd_ready = !r_pend_full;

    // Scan slot index, advances once per prescaler period
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_idx <= r_idx + 2'd1;
        end else begin
            r_idx <= r_idx;
        end
    end

    // Double buffer: a new value is parked in pending and only moves to
    // active on a frame boundary. An accept that coincides with a boundary
    // (pending empty) still waits a full frame; there is no bypass path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
        end else begin
            if (w_boundary && r_pend_full) begin
                r_active    <= r_pending;
                r_pend_full <= 1'b0;
            end
            if (w_accept) begin
                r_pending.d   <= upd_if.upd_value;
                r_pending.neg <= upd_if.upd_neg;
                r_pend_full   <= 1'b1;
            end
        end
    end

    assign w_d3z = (r_active.d[3] == 4'd0);
    assign w_d2z = (r_active.d[2] == 4'd0);
    assign w_d1z = (r_active.d[1] == 4'd0);

    // Slot content: with a minus sign in slot 3, blanking of slots 1/2
    // only looks at digits up to slot 2; slot 0 is never blanked.
    always_comb begin
        w_blank = 1'b0;
        w_code  = r_active.d[r_idx];
        w_anode = anode_for_slot(r_idx);
        w_dp    = 1'b0;
        if (show_ans) begin
            case (r_idx)
                2'd3: begin
                    if (r_active.neg) begin
                        w_code = CODE_DASH;
                    end else begin
                        w_blank = w_d3z;
                    end
                end
                2'd2: begin
                    if (r_active.neg) begin
                        w_blank = w_d2z;
                    end else begin
                        w_blank = w_d3z & w_d2z;
                    end
                end
                2'd1: begin
                    if (r_active.neg) begin
                        w_blank = w_d2z & w_d1z;
                    end else begin
                        w_blank = w_d3z & w_d2z & w_d1z;
                    end
                end
                default: begin
                    w_blank = 1'b0;
                end
            endcase
        end else begin
            w_dp = (r_idx == 2'd1);
        end
    end

    // Registered display outputs and frame pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable     <= AN_OFF;
            digit      <= 4'd0;
            dp_on      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            enable     <= w_blank ? AN_OFF : w_anode;
            digit      <= w_blank ? 4'd0 : w_code;
            dp_on      <= w_dp;
            frame_done <= w_boundary;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with REFRESH_DIV=4.
// n counts clock edges since reset release; a frame is 16 edges, the
// boundary falls on edges where n is a multiple of 16, and slot s is shown
// on edges n with ((n-1)/4)%4 == s.
module tb_display_scan_controller;

    logic       clk;
    logic       rst_n;
    logic       show_ans;
    logic [3:0] enable;
    logic [3:0] digit;
    logic       dp_on;
    logic       frame_done;

    int errors;
    int checks;
    int n;

    display_scan_controller_if u_if ();

    display_scan_controller #(
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_if     (u_if),
        .show_ans   (show_ans),
        .enable     (enable),
        .digit      (digit),
        .dp_on      (dp_on),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    task automatic rst_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        chk("frame_done", {15'd0, frame_done}, ((n % 16) == 0) ? 16'd1 : 16'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_enable", {12'd0, enable}, 16'h000F);
        chk("rst_digit", {12'd0, digit}, 16'h0000);
        chk("rst_dp", {15'd0, dp_on}, 16'h0000);
        chk("rst_frame_done", {15'd0, frame_done}, 16'h0000);
        chk("rst_ready", {15'd0, u_if.upd_ready}, 16'h0001);
    endtask

    // en16/dig16/dp4 hold the expected outputs per slot, slot 0 in the low nibble/bit
    task automatic run_check(input int steps, input logic [15:0] en16,
                             input logic [15:0] dig16, input logic [3:0] dp4);
        int slot;
        for (int i = 0; i < steps; i++) begin
            step();
            slot = ((n - 1) / 4) % 4;
            chk("enable", {12'd0, enable}, {12'd0, en16[slot*4 +: 4]});
            chk("digit", {12'd0, digit}, {12'd0, dig16[slot*4 +: 4]});
            chk("dp_on", {15'd0, dp_on}, {15'd0, dp4[slot]});
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        n = 0;
        rst_n = 1'b0;
        show_ans = 1'b0;
        u_if.upd_value = 16'h0000;
        u_if.upd_neg = 1'b0;
        u_if.upd_valid = 1'b0;

        // Reset state
        rst_step();
        rst_step();
        chk_reset_vals();

        // Plain scan of value 0 in entry mode
        rst_n = 1'b1;
        n = 0;
        run_check(16, 16'h7BDE, 16'h0000, 4'b0010);

        // Entry mode: 1234 accepted mid-frame, shown after next boundary
        run_check(4, 16'h7BDE, 16'h0000, 4'b0010);
        u_if.upd_value = 16'h1234;
        u_if.upd_valid = 1'b1;
        run_check(1, 16'h7BDE, 16'h0000, 4'b0010);
        chk("ready_after_accept", {15'd0, u_if.upd_ready}, 16'h0000);
        u_if.upd_valid = 1'b0;
        run_check(11, 16'h7BDE, 16'h0000, 4'b0010);
        chk("ready_after_boundary", {15'd0, u_if.upd_ready}, 16'h0001);
        run_check(16, 16'h7BDE, 16'h1234, 4'b0010);

        // Back-pressure: 0001 then 0002 held until ready returns
        u_if.upd_value = 16'h0001;
        u_if.upd_valid = 1'b1;
        run_check(1, 16'h7BDE, 16'h1234, 4'b0010);
        chk("bp_ready_low", {15'd0, u_if.upd_ready}, 16'h0000);
        u_if.upd_value = 16'h0002;
        run_check(15, 16'h7BDE, 16'h1234, 4'b0010);
        chk("bp_ready_back", {15'd0, u_if.upd_ready}, 16'h0001);
        run_check(1, 16'h7BDE, 16'h0001, 4'b0010);
        chk("bp_second_taken", {15'd0, u_if.upd_ready}, 16'h0000);
        u_if.upd_valid = 1'b0;
        run_check(15, 16'h7BDE, 16'h0001, 4'b0010);
        run_check(16, 16'h7BDE, 16'h0002, 4'b0010);

        // Answer mode: 0002 blanks to a single digit; load 0050
        show_ans = 1'b1;
        u_if.upd_value = 16'h0050;
        u_if.upd_valid = 1'b1;
        run_check(1, 16'hFFFE, 16'h0002, 4'b0000);
        u_if.upd_valid = 1'b0;
        run_check(15, 16'hFFFE, 16'h0002, 4'b0000);

        // 0050: slots 3,2 blank, slot 1 shows 5, slot 0 shows 0; load 0000
        u_if.upd_value = 16'h0000;
        u_if.upd_valid = 1'b1;
        run_check(1, 16'hFFDE, 16'h0050, 4'b0000);
        u_if.upd_valid = 1'b0;
        run_check(15, 16'hFFDE, 16'h0050, 4'b0000);

        // 0000: only slot 0 lit; load -7
        u_if.upd_value = 16'h0007;
        u_if.upd_neg = 1'b1;
        u_if.upd_valid = 1'b1;
        run_check(1, 16'hFFFE, 16'h0000, 4'b0000);
        u_if.upd_valid = 1'b0;
        run_check(15, 16'hFFFE, 16'h0000, 4'b0000);

        // -7: dash in slot 3, slots 2,1 blank, 7 in slot 0
        run_check(16, 16'h7FFE, 16'hA007, 4'b0000);

        // Entry mode ignores sign; park 9999 in pending
        show_ans = 1'b0;
        u_if.upd_value = 16'h9999;
        u_if.upd_neg = 1'b0;
        u_if.upd_valid = 1'b1;
        run_check(1, 16'h7BDE, 16'h0007, 4'b0010);
        chk("pend_full_before_rst", {15'd0, u_if.upd_ready}, 16'h0000);
        u_if.upd_valid = 1'b0;
        run_check(7, 16'h7BDE, 16'h0007, 4'b0010);

        // One-cycle reset with pending full and idx=2
        rst_n = 1'b0;
        rst_step();
        chk_reset_vals();
        rst_n = 1'b1;
        n = 0;
        run_check(16, 16'h7BDE, 16'h0000, 4'b0010);
        run_check(16, 16'h7BDE, 16'h0000, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexing scan controller for the 4-digit seven-segment display. It owns the anode enables and feeds one BCD code per slot to the `segmentDisplay` decoder. It double-buffers a 16-bit BCD value so updates land only on frame boundaries, which prevents tearing. It also applies answer-mode leading-zero blanking and the minus sign.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot; must be ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `upd_value`  in  16  four BCD digits; [3:0] rightmost, [15:12] leftmost.
- `upd_neg`  in  1  value is negative; shown only in answer mode.
- `upd_valid`  in  1  update offered.
- `upd_ready`  out  1  pending buffer empty; update accepted when `upd_valid && upd_ready`.
- `show_ans`  in  1  answer mode: blanking and sign enabled, decimal point suppressed.
- `enable`  out  4  active-low anodes; exactly one low or all high.
- `digit`  out  4  code to decoder; 10 = dash.
- `dp_on`  out  1  decimal point request for the current slot.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- **Prescaler:** counts 0..REFRESH_DIV-1 and wraps. `tick` is true in the cycle the count equals REFRESH_DIV-1.
- **Scan index:**
  - `idx` (0..3) increments on `tick` and wraps 3→0.
  - Anodes by slot: idx 0→4'b1110, 1→4'b1101, 2→4'b1011, 3→4'b0111.
- **Frame boundary:** `tick && idx==3`.
- **Buffers:** `active` and `pending`, each 16-bit value plus neg bit; `pend_full` flag.
  - Accept: `pending` ← input, `pend_full` ← 1.
  - Boundary with `pend_full`: `active` ← `pending`, `pend_full` ← 0.
  - Accept and boundary in the same cycle with `pend_full`=0: data goes to `pending` and is applied at the next boundary. There is no bypass.
  - `upd_ready` = !`pend_full`.
- **Slot content, answer mode** (`show_ans`=1, `d[k]` = active digit k):
  - Slot k∈{1,2} is blanked if `d[j]`==0 for every j with k≤j≤3. Slot 3 is blanked if `d[3]`==0.
  - If neg=1, slot 3 shows code 10 instead of `d[3]` and is never blanked. Slots 1 and 2 are then blanked only when `d[j]`==0 for every j with k≤j≤2.
  - Slot 0 is never blanked; a value of 0 shows "0".
  - A blanked slot drives `enable`=4'b1111 and `digit`=0.
  - `dp_on`=0.
- **Slot content, entry mode** (`show_ans`=0):
  - No blanking or sign.
  - `digit`=`d[idx]`.
  - `dp_on`=1 exactly when idx==1.
- **Codes 10–15** in `upd_value` are forwarded unchanged. They are not checked.
- **`show_ans` sampling:** sampled every cycle and takes effect on the next output register update, including mid-frame.

## Timing
- **Reset values:**
  - Outputs: `enable`=4'b1111, `digit`=0, `dp_on`=0, `frame_done`=0, `upd_ready`=1.
  - Internal state: prescaler 0, idx 0, `active` value 0 with neg 0, `pend_full` 0.
- **Output registers:** `enable`, `digit`, `dp_on` are registered from `idx`, `active` and `show_ans`. They reflect a new idx one cycle after the `tick` that changed it.
- **First slot after reset:** the cycle after `rst_n` rises, outputs show slot 0 of value 0, i.e. `enable`=4'b1110, `digit`=0.
- **`frame_done`:** registered; high the cycle after the boundary. This is the same cycle `active` holds the new value and idx=0.
- **Update latency:** from acceptance to display is at most one frame plus one slot, i.e. 5·REFRESH_DIV+1 cycles.
- **Handshake:** `upd_ready` deasserts the cycle after acceptance and reasserts the cycle after the consuming boundary. `upd_valid` without `upd_ready` has no effect and requires no retention.
- **Reset mid-frame:** asserting `rst_n` low in any cycle discards `pending` and `active` and returns to the reset state on the next edge.

## Structure
- **Package `display_pkg`:**
  - Anode constants `AN_SLOT0..AN_SLOT3` and `AN_OFF`=4'b1111.
  - `CODE_DASH`=4'd10.
  - `NUM_DIGITS`=4.
  - Typedef `bcd4_t` (packed 4×4-bit) with its neg bit.
- **Sub-module `refresh_tick`:** parameterised prescaler producing `tick`. It is reused by future blink/timeout logic.
- Scan, buffering and blanking stay in this module.

## Test plan
- **Reset and scan:** REFRESH_DIV=4, reset, no updates → `enable` cycles 1110,1101,1011,0111 every 4 cycles. `digit`=0 throughout. `frame_done` pulses every 16 cycles.
- **Entry-mode display:** `show_ans`=0, update 16'h1234 accepted mid-frame → unchanged until the next boundary. Then slots 0..3 show 4,3,2,1, with `dp_on`=1 only while `enable`=1101.
- **Back-pressure:** two back-to-back updates 16'h0001 then 16'h0002 → first accepted and `upd_ready` low. Second is held off until the cycle after the boundary, accepted then, and displayed one frame later.
- **Blanking:** `show_ans`=1, value 16'h0050, neg=0 → slots 3 and 2 blanked (`enable`=1111), slot 1 shows 5, slot 0 shows 0. Value 16'h0000 → only slot 0 lit, showing 0.
- **Negative:** `show_ans`=1, value 16'h0007, neg=1 → slot 3 shows 10, slots 2 and 1 blanked, slot 0 shows 7, `dp_on`=0.
- **Reset mid-operation:** `pend_full`=1 and idx=2, pulse `rst_n` low for one cycle → next cycle all reset values; previously pending data is never displayed.
